// File: rtl/trip_vote_latch_pkg.sv
// rts_vote_pkg: shared defaults, channel indices and trip-vector bit addressing
// for the trip vote latch.
package rts_vote_pkg;
   localparam int NDIVISIONS_DEF = 4;
   localparam int NCHANNELS_DEF = 3;
   localparam int CH_TEMPERATURE = 0;
   localparam int CH_PRESSURE = 1;
   localparam int CH_SATURATION = 2;
   // Division 0 sits in the most significant slice, channel 0 in the
   // most significant bit of its slice.
   function automatic int bit_pos(input int nd, input int nc, input int d, input int ch);
      return nc * (nd - d - 1) + nc - ch - 1;
   endfunction
endpackage

// File: rtl/trip_vote_latch_if.sv
// trip_vote_latch_if: division reports and operator controls in, vote/latch status out.
//   trip_valid, trip          per-division strobe and trip slices
//   manual_trip, clear_req    operator controls
//   vote, stale, actuate, clear_ack  latch status
// master = the divisions/operator side, slave = the vote latch.
interface trip_vote_latch_if #(
   parameter int NDivisions = 4,
   parameter int NChannels = 3
);
   logic [NDivisions-1:0] trip_valid;
   logic [NDivisions*NChannels-1:0] trip;
   logic manual_trip;
   logic clear_req;
   logic [NChannels-1:0] vote;
   logic [NDivisions-1:0] stale;
   logic actuate;
   logic clear_ack;
   modport master (
      output trip_valid, trip, manual_trip, clear_req,
      input vote, stale, actuate, clear_ack
   );
   modport slave (
      input trip_valid, trip, manual_trip, clear_req,
      output vote, stale, actuate, clear_ack
   );
endinterface

// File: rtl/trip_vote_latch_persist.sv
// trip_persist_filter: passes a channel vote only after raw has held for
// PersistCycles consecutive cycles.
//   clk, rst  clock and synchronous active-high reset
//   raw       unfiltered coincidence vote
//   vote      persistence-filtered vote (drops one cycle after raw)
module trip_persist_filter #(
   parameter int PersistCycles = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic vote
);
   localparam int W = PersistCycles > 1 ? $clog2(PersistCycles) : 1;
   localparam logic [W-1:0] LAST = W'(PersistCycles - 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         vote <= 1'b0;
      end else begin
         cnt <= !raw ? '0 : (cnt == LAST ? LAST : cnt + W'(1));
         vote <= raw && cnt == LAST;
      end
   end
endmodule

// File: rtl/trip_vote_latch.sv
// trip_vote_latch: registers division trip reports, votes coincidence per
// channel with silent divisions counted as tripped, filters for persistence
// and latches the actuation demand until a permitted clear.
//   clk, rst  clock and synchronous active-high reset
//   bus       trip_vote_latch_if slave: trip_valid, trip, manual_trip,
//             clear_req in; vote, stale, actuate, clear_ack out
module trip_vote_latch
   import rts_vote_pkg::*;
#(
   parameter int NDivisions = NDIVISIONS_DEF,
   parameter int NChannels = NCHANNELS_DEF,
   parameter int VoteThreshold = 2,
   parameter int PersistCycles = 4,
   parameter int StaleTimeout = 16
) (
   input logic clk,
   input logic rst,
   trip_vote_latch_if.slave bus
);
   localparam int CW = $clog2(NDivisions + 1);
   localparam int SW = $clog2(StaleTimeout + 1);
   localparam logic [SW-1:0] ST = SW'(StaleTimeout);
   // div_reg is indexed [division][channel] in logical order.
   logic [NChannels-1:0] div_reg [NDivisions];
   logic [SW-1:0] stale_cnt [NDivisions];
   logic [SW-1:0] stale_nxt [NDivisions];
   logic [NDivisions-1:0] stale_r;
   logic [CW-1:0] tcount [NChannels];
   logic [NChannels-1:0] raw;
   logic [NChannels-1:0] vote_r;
   logic actuate_r, clear_ack_r, set, clr_ok;
   always_comb begin
      for (int d = 0; d < NDivisions; d++)
         stale_nxt[d] = stale_cnt[d] == ST ? ST : stale_cnt[d] + SW'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < NDivisions; d++) begin
            div_reg[d] <= '0;
            stale_cnt[d] <= '0;
         end
         stale_r <= '0;
      end else begin
         for (int d = 0; d < NDivisions; d++) begin
            if (bus.trip_valid[NDivisions-1-d]) begin
               for (int ch = 0; ch < NChannels; ch++)
                  div_reg[d][ch] <= bus.trip[bit_pos(NDivisions, NChannels, d, ch)];
               stale_cnt[d] <= '0;
               stale_r[NDivisions-1-d] <= 1'b0;
            end else begin
               stale_cnt[d] <= stale_nxt[d];
               stale_r[NDivisions-1-d] <= stale_nxt[d] == ST;
            end
         end
      end
   end
   // A stale division counts as tripped on every channel (fail-safe).
   always_comb begin
      for (int ch = 0; ch < NChannels; ch++) begin
         tcount[ch] = '0;
         for (int d = 0; d < NDivisions; d++)
            tcount[ch] = tcount[ch] + CW'(div_reg[d][ch] | stale_r[NDivisions-1-d]);
         raw[ch] = tcount[ch] >= CW'(VoteThreshold);
      end
   end
   for (genvar c = 0; c < NChannels; c++) begin : g_persist
      trip_persist_filter #(.PersistCycles(PersistCycles)) u_filter (
         .clk(clk),
         .rst(rst),
         .raw(raw[c]),
         .vote(vote_r[NChannels-1-c])
      );
   end
   assign set = (|vote_r) | bus.manual_trip;
   assign clr_ok = bus.clear_req & ~(|raw) & ~(|vote_r) & ~bus.manual_trip;
   always_ff @(posedge clk) begin
      if (rst) begin
         actuate_r <= 1'b0;
         clear_ack_r <= 1'b0;
      end else begin
         actuate_r <= set ? 1'b1 : (clr_ok ? 1'b0 : actuate_r);
         clear_ack_r <= clr_ok & actuate_r;
      end
   end
   assign bus.vote = vote_r;
   assign bus.stale = stale_r;
   assign bus.actuate = actuate_r;
   assign bus.clear_ack = clear_ack_r;
endmodule

// File: tb/tb_trip_vote_latch.sv
// tb_trip_vote_latch: directed scenarios plus random traffic against a
// behavioural model; expected outputs are queued per cycle and checked by
// an independent monitor.
module tb_trip_vote_latch;
   localparam int ND = 4;
   localparam int NC = 3;
   localparam int VT = 2;
   localparam int PC = 4;
   localparam int ST = 16;
   localparam int W = NC + ND + 2;
   logic clk = 1'b0;
   logic rst;
   trip_vote_latch_if #(.NDivisions(ND), .NChannels(NC)) bus ();
   trip_vote_latch #(
      .NDivisions(ND), .NChannels(NC), .VoteThreshold(VT),
      .PersistCycles(PC), .StaleTimeout(ST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   logic [W-1:0] sbq [$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit m_dreg [ND][NC];
   int m_silent [ND];
   int m_run [NC];
   bit m_stale [ND];
   bit m_vote [NC];
   bit m_act;
   // Model: raw vote counts tripped-or-silent divisions; vote needs PC
   // consecutive raw cycles; actuate latches until an allowed clear.
   task automatic model_step(input logic r, input logic [ND-1:0] v,
                             input logic [ND*NC-1:0] t, input logic m, input logic c);
      logic [W-1:0] e;
      bit raw [NC];
      bit anyr, anyv, clr, ack;
      int cnt;
      e = '0;
      ack = 0;
      if (r) begin
         for (int d = 0; d < ND; d++) begin
            for (int ch = 0; ch < NC; ch++) m_dreg[d][ch] = 0;
            m_silent[d] = 0;
            m_stale[d] = 0;
         end
         for (int ch = 0; ch < NC; ch++) begin
            m_run[ch] = 0;
            m_vote[ch] = 0;
         end
         m_act = 0;
      end else begin
         anyr = 0;
         anyv = 0;
         for (int ch = 0; ch < NC; ch++) begin
            cnt = 0;
            for (int d = 0; d < ND; d++) if (m_dreg[d][ch] || m_stale[d]) cnt++;
            raw[ch] = cnt >= VT;
            anyr |= raw[ch];
            anyv |= m_vote[ch];
         end
         clr = c && !anyr && !anyv && !m;
         ack = clr && m_act;
         m_act = (anyv || m) ? 1'b1 : (clr ? 1'b0 : m_act);
         for (int ch = 0; ch < NC; ch++) begin
            m_run[ch] = raw[ch] ? m_run[ch] + 1 : 0;
            m_vote[ch] = m_run[ch] >= PC;
         end
         for (int d = 0; d < ND; d++) begin
            if (v[ND-1-d]) begin
               for (int ch = 0; ch < NC; ch++) m_dreg[d][ch] = t[NC*(ND-1-d) + NC-1-ch];
               m_silent[d] = 0;
            end else m_silent[d]++;
            m_stale[d] = m_silent[d] >= ST;
         end
      end
      for (int ch = 0; ch < NC; ch++) e[ND + 2 + NC-1-ch] = m_vote[ch];
      for (int d = 0; d < ND; d++) e[2 + ND-1-d] = m_stale[d];
      e[1] = m_act;
      e[0] = ack;
      sbq.push_back(e);
   endtask
   task automatic drv(input logic r, input logic [ND-1:0] v, input logic [ND*NC-1:0] t,
                      input logic m, input logic c);
      @(negedge clk);
      rst = r;
      bus.trip_valid = v;
      bus.trip = t;
      bus.manual_trip = m;
      bus.clear_req = c;
      model_step(r, v, t, m, c);
   endtask
   function automatic logic [ND*NC-1:0] pack4(input logic [2:0] s0, s1, s2, s3);
      return {s0, s1, s2, s3};
   endfunction
   always @(posedge clk) begin
      logic [W-1:0] exp_v, got;
      #1;
      cyc++;
      if (sbq.size() > 0) begin
         exp_v = sbq.pop_front();
         got = {bus.vote, bus.stale, bus.actuate, bus.clear_ack};
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d got vote/stale/act/ack=%b required=%b", cyc, got, exp_v);
         end
      end
   end
   initial begin
      logic [ND*NC-1:0] p, t;
      logic [ND-1:0] v;
      rst = 1'b1;
      bus.trip_valid = '0;
      bus.trip = '0;
      bus.manual_trip = 1'b0;
      bus.clear_req = 1'b0;
      p = pack4(3'b010, 3'b010, 3'b000, 3'b000);
      // two divisions report pressure, everyone re-reports every 4 cycles
      repeat (2) drv(1, '0, '0, 0, 0);
      for (int k = 0; k < 20; k++)
         drv(0, k == 0 ? 4'b1100 : (k % 4 == 0 ? 4'b1111 : 4'b0000), p, 0, 0);
      // raw vote glitch restarts persistence
      repeat (2) drv(1, '0, '0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         v = k == 0 ? 4'b1100 : (k == 3 || k == 4) ? 4'b0100 : (k % 4 == 0 ? 4'b1111 : 4'b0000);
         drv(0, v, k == 3 ? pack4(3'b010, 3'b000, 3'b000, 3'b000) : p, 0, 0);
      end
      // silent divisions go stale and trip every channel
      repeat (2) drv(1, '0, '0, 0, 0);
      for (int k = 0; k < 24; k++) drv(0, k % 4 == 0 ? 4'b1000 : 4'b0000, '0, 0, 0);
      // clear denied while stale votes are active
      for (int k = 0; k < 3; k++) drv(0, k == 0 ? 4'b1000 : 4'b0000, '0, 0, 1);
      // all divisions report clean, then clear is accepted
      drv(0, 4'b1111, '0, 0, 0);
      repeat (3) drv(0, '0, '0, 0, 0);
      drv(0, '0, '0, 0, 1);
      repeat (2) drv(0, '0, '0, 0, 0);
      // manual trip wins over a simultaneous clear, then a clean clear
      drv(0, 4'b1111, '0, 1, 1);
      drv(0, '0, '0, 0, 1);
      repeat (2) drv(0, '0, '0, 0, 0);
      // reset mid-operation, then a 1-of-4 report never votes
      repeat (2) drv(1, '0, '0, 0, 0);
      for (int k = 0; k < 8; k++)
         drv(0, k == 0 ? 4'b1100 : (k % 4 == 0 ? 4'b1111 : 4'b0000), p, 0, 0);
      drv(1, '0, '0, 0, 0);
      for (int k = 0; k < 12; k++)
         drv(0, k % 4 == 0 ? 4'b1000 : 4'b0000, pack4(3'b010, 3'b000, 3'b000, 3'b000), 0, 0);
      // random traffic
      for (int k = 0; k < 400; k++) begin
         for (int d = 0; d < ND; d++) v[d] = $urandom_range(0, 3) == 0;
         for (int b = 0; b < ND * NC; b++) t[b] = $urandom_range(0, 4) == 0;
         drv($urandom_range(0, 99) == 0, v, t, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/trip_vote_latch.md
Name: trip_vote_latch

Overview:
- Consumer end of the per-division sensor trip vectors produced by the instrumentation divisions (NChannels trip bits per division, channel 2 is saturation margin).
- Registers each division's latest report and votes coincidence (VoteThreshold-of-NDivisions) per channel.
- Filters each channel vote for persistence and latches the actuation demand until an explicit, permitted clear.
- Treats a silent division as fully tripped (fail-safe).

Parameters:
- NDivisions, 4, number of reporting instrumentation divisions.
- NChannels, 3, trip channels per division (matches the trip generator).
- VoteThreshold, 2, tripped divisions required per channel; legal range 1..NDivisions.
- PersistCycles, 4, consecutive cycles the raw vote must hold; >=1.
- StaleTimeout, 16, cycles without trip_valid before a division is stale; >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- trip_valid  in  NDivisions  per-division strobe; bit NDivisions-d-1 belongs to division d.
- trip  in  NDivisions*NChannels  division d occupies bits [NChannels*(NDivisions-d-1) +: NChannels]; channel ch is bit NChannels-ch-1 within that slice.
- manual_trip  in  1  operator trip demand, level-sensitive.
- clear_req  in  1  operator request to release the latched actuation.
- vote  out  NChannels  persistence-filtered coincidence per channel, same bit ordering as a division slice.
- stale  out  NDivisions  division has exceeded StaleTimeout.
- actuate  out  1  latched actuation demand.
- clear_ack  out  1  one-cycle pulse: clear accepted.

Behaviour:
- Reset (synchronous, rst=1 at an edge) clears all state: every div_reg, stale_cnt and persist_cnt = 0; vote = 0, stale = 0, actuate = 0, clear_ack = 0. rst overrides every other input in the same cycle, including manual_trip.
- Division register: if trip_valid[d], div_reg[d] <= slice d. The value is visible the next cycle. Otherwise div_reg[d] holds.
- Staleness:
  - trip_valid[d] sets stale_cnt[d] <= 0 and stale[d] <= 0.
  - Otherwise stale_cnt[d] increments, saturating at StaleTimeout. stale[d] <= (next stale_cnt == StaleTimeout).
  - A stale division contributes 1 on every channel. A fresh trip_valid removes this contribution on the following cycle.
- Raw vote (combinational from registered state): tripped_count[ch] = sum over d of (div_reg[d][ch] | stale[d]), width $clog2(NDivisions+1). raw[ch] = tripped_count[ch] >= VoteThreshold.
- Persistence, per channel:
  - If raw[ch], persist_cnt <= min(persist_cnt+1, PersistCycles-1); otherwise persist_cnt <= 0.
  - vote[ch] <= raw[ch] && (persist_cnt == PersistCycles-1).
  - vote drops one cycle after raw drops; vote itself is not latched.
- Latency: trip_valid in cycle t with a qualifying pattern gives vote visible at t+PersistCycles+1, and actuate visible at t+PersistCycles+2. manual_trip in cycle t gives actuate at t+1.
- Actuation latch:
  - set = (|vote) | manual_trip.
  - clr_ok = clear_req & ~(|raw) & ~(|vote) & ~manual_trip.
  - actuate <= set ? 1 : (clr_ok ? 0 : actuate). Set wins over clear in the same cycle.
  - clear_ack <= clr_ok & actuate. A denied clear or a clear while not actuated gives no ack; the request is not remembered.
- A raw vote interrupted for even one cycle restarts the PersistCycles count.
- Simultaneous trip_valid on several divisions: all update in the same cycle; there is no arbitration.

Decomposition:
- Package rts_vote_pkg holds:
  - NDivisions, NChannels defaults.
  - Channel index constants CH_TEMPERATURE=0, CH_PRESSURE=1, CH_SATURATION=2.
  - A function for the slice offset of division d / channel ch.
- Sub-module trip_persist_filter (one instance per channel): inputs clk, rst, raw; output vote. Contains the persistence counter; parameter PersistCycles.
- Vote counting and staleness stay inline in the top.

Test Plan:
- Two divisions report pressure: trip_valid=4'b1100, trip slices d0=3'b010, d1=3'b010, d2=d3=0 at t=10, then each division re-reports its same slice every 4 cycles. Required: vote=3'b010 first at t=15, actuate=1 at t=16, stale stays 0.
- Raw vote glitch: same pattern, but at t=13 d1 reports 3'b000 and at t=14 reports 3'b010 again. Required: persistence restarts, vote rises at t=19, and no actuate before t=20.
- Stale fail-safe: after reset, d0 re-reports 3'b000 every 4 cycles while d1..d3 are silent. Required: stale=4'b0111 after 16 cycles, vote=3'b111 four cycles later, and actuate set.
- Clear handling: with actuate=1, clear_req while vote or raw is active gives no clear_ack and actuate stays 1. After all divisions report 0, clear_req gives clear_ack pulse and actuate=0 next cycle.
- Manual trip plus simultaneous clear_req: actuate=1 at t+1, no clear_ack. Then manual_trip=0 with clear_req gives a successful clear.
- Mid-operation reset: rst at t while actuate=1 and persist counters are nonzero. Required: at t+1 all outputs are 0, and a clean 1-of-4 report (d0 only) never asserts vote.
